// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch : RV32I fetch stage
//
// Owns the program counter and issues one request at a time to instruction
// memory. Returned words are buffered in a small FIFO together with the PC
// they were fetched from. The head entry is presented to decode through a
// valid/ready handshake, with the opcode fields already split out. A redirect
// from execute flushes the buffer, withdraws any unaccepted request and
// discards the response of a request that is still in flight.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr      request channel to instruction memory
//   imem_rsp_valid/data            response channel (>= 1 cycle after accept)
//   redirect, redirect_pc          taken branch/jump from execute
//   instr_valid/ready              head-of-buffer handshake to decode
//   instr, instr_pc                head word and its PC (NOP / 0 when empty)
//   op_code, func3, func7          instr[6:0], instr[14:12], instr[31:25]
//   fetch_fault                    misaligned redirect target seen (sticky)
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect whose target has
//                           non-zero low bits raises fetch_fault, flushes the
//                           buffer and halts fetching until reset. When not
//                           defined the low bits are silently cleared and
//                           fetch_fault is tied low.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op_code,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic        fetch_fault
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]      r_pc;
  logic [31:0]      r_req_pc;
  logic             r_drop;
  logic [31:0]      r_fifo_instr [FIFO_DEPTH];
  logic [31:0]      r_fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_fault;
  logic             w_inflight;
  logic             w_credit;
  logic             w_req_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_drop_next;
  logic [CNT_W-1:0] w_count_next;
  logic [31:0]      w_redirect_target;

  // Low two bits are always cleared: fetch addresses are word aligned.
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // -------------------------------------------------------------------------
  // Optional misaligned-redirect trap
  // -------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;
  logic w_misalign;

  assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_misalign) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  assign fetch_fault = w_fault;

  // -------------------------------------------------------------------------
  // Request credit: buffered entries plus the one possible in-flight request
  // must stay below the buffer depth, so a response always has a free slot.
  // -------------------------------------------------------------------------
  assign w_inflight = (r_state == ST_WAIT);
  assign w_credit   = (r_count + {{(CNT_W-1){1'b0}}, w_inflight}) < DEPTH_CNT;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and request/response control
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    w_req_fire     = 1'b0;
    w_push         = 1'b0;
    w_drop_next    = r_drop;
    case (r_state)
      ST_REQ: begin
        // A redirect withdraws the request in the same cycle, so an
        // acceptance can never coincide with a redirect.
        imem_req_valid = w_credit && !redirect && !w_fault && !rst;
        if (imem_req_valid && imem_req_ready) begin
          w_req_fire   = 1'b1;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          if (imem_rsp_valid) begin
            // Response arriving with the redirect belongs to the old path.
            w_drop_next  = 1'b0;
            w_state_next = ST_REQ;
          end else begin
            // Still waiting: remember to discard the stale word later.
            w_drop_next = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          w_push       = !r_drop && !w_fault;
          w_drop_next  = 1'b0;
          w_state_next = ST_REQ;
        end
      end
      default: begin
        w_state_next = ST_REQ;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Buffer occupancy
  // -------------------------------------------------------------------------
  assign instr_valid = (r_count != '0) && !rst;
  assign w_pop       = instr_valid && instr_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // -------------------------------------------------------------------------
  // PC, pointers and drop flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= w_drop_next;
      if (redirect) begin
        // Flush everything younger than the redirect, including a head
        // that decode consumes in this same cycle.
        r_pc     <= w_redirect_target;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= w_count_next;
      end
    end
  end

  // PC of the outstanding request and the buffer payload carry no reset;
  // they are only observed once qualified by state or occupancy.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_req_pc <= r_pc;
    end
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs to decode
  // -------------------------------------------------------------------------
  assign imem_addr = r_pc;
  assign instr     = instr_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
  assign instr_pc  = instr_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0000_0000;
  assign op_code   = instr[6:0];
  assign func3     = instr[14:12];
  assign func7     = instr[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op_code;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        fetch_fault;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op_code        (op_code),
    .func3          (func3),
    .func7          (func7),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs [4];

  int n_checks = 0;
  int n_pass   = 0;

  // imem / reference model state
  bit          pend        = 1'b0;
  bit          pend_stale  = 1'b0;
  bit          hold_rsp    = 1'b0;
  bit          req_rdy     = 1'b1;
  bit          model_fault = 1'b0;
  logic [31:0] pend_addr   = 32'h0;
  logic [31:0] exp_pc      = 32'h0;

  // last observed handshakes
  bit          popped        = 1'b0;
  logic [31:0] pop_instr     = 32'h0;
  logic [31:0] pop_pc        = 32'h0;
  logic [6:0]  pop_op        = 7'h0;
  logic [2:0]  pop_f3        = 3'h0;
  logic [6:0]  pop_f7        = 7'h0;
  bit          last_acc      = 1'b0;
  logic [31:0] last_acc_addr = 32'h0;
  bit          prev_valid    = 1'b0;
  bit          prev_consumed = 1'b0;
  logic [31:0] prev_instr    = 32'h0;
  logic [31:0] prev_pc       = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'd16) return vecs[addr[3:2]].word;
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_req_valid",   32'(imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(instr_valid),    32'd0);
      check("rst_instr",       instr,               NOP);
      check("rst_instr_pc",    instr_pc,            32'h0);
      check("rst_fetch_fault", 32'(fetch_fault),    32'd0);
    end
    exp_q.delete();
    pend        = 1'b0;
    pend_stale  = 1'b0;
    hold_rsp    = 1'b0;
    model_fault = 1'b0;
    exp_pc      = 32'h0;
    prev_valid  = 1'b0;
    popped      = 1'b0;
    rst         = 1'b0;
    #1;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          acc;
    bit          rsp;
    bit          pop;
    logic [31:0] acc_addr;
    exp_t        e;
    instr_ready    = rdy;
    redirect       = redir;
    redirect_pc    = rpc;
    imem_req_ready = req_rdy;
    rsp            = pend && !hold_rsp;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
    check("fetch_fault", 32'(fetch_fault), 32'(model_fault));
    if (prev_valid && !prev_consumed) begin
      check("head_stable_valid", 32'(instr_valid), 32'd1);
      check("head_stable_instr", instr,    prev_instr);
      check("head_stable_pc",    instr_pc, prev_pc);
    end
    if (!instr_valid) begin
      check("empty_instr", instr,    NOP);
      check("empty_pc",    instr_pc, 32'h0);
    end
    if (redir) check("req_gated_by_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid)
      check("req_credit", 32'((exp_q.size() + int'(pend)) < DEPTH), 32'd1);
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    if (acc) check("req_addr", imem_addr, exp_pc);
    pop = instr_valid && instr_ready;
    if (pop) begin
      check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr",    instr,         e.data);
        check("instr_pc", instr_pc,      e.pc);
        check("op_code",  32'(op_code),  32'(e.data[6:0]));
        check("func3",    32'(func3),    32'(e.data[14:12]));
        check("func7",    32'(func7),    32'(e.data[31:25]));
      end
      popped    = 1'b1;
      pop_instr = instr;
      pop_pc    = instr_pc;
      pop_op    = op_code;
      pop_f3    = func3;
      pop_f7    = func7;
    end
    prev_valid    = instr_valid;
    prev_instr    = instr;
    prev_pc       = instr_pc;
    prev_consumed = pop || redir;
    last_acc      = acc;
    last_acc_addr = acc_addr;
    @(posedge clk); #1;
    if (rsp) begin
      if (!pend_stale && !redir && !model_fault) begin
        e.data = mem_word(pend_addr);
        e.pc   = pend_addr;
        exp_q.push_back(e);
      end
      pend = 1'b0;
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = rpc & 32'hFFFF_FFFC;
      if (pend) pend_stale = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) model_fault = 1'b1;
`endif
    end
    if (acc) begin
      pend       = 1'b1;
      pend_stale = 1'b0;
      pend_addr  = acc_addr;
      exp_pc     = exp_pc + 32'd4;
    end
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
  endtask

  task automatic wait_pop(input string name);
    popped = 1'b0;
    for (int k = 0; k < 20 && !popped; k++) cycle(1'b1, 1'b0, 32'h0);
    check(name, 32'(popped), 32'd1);
  endtask

  initial begin
    int          nacc;
    logic [31:0] a1;
    logic [31:0] a2;

    vecs[0] = '{pc: 32'h0, word: 32'h0050_0093, op: 7'h13, f3: 3'h0, f7: 7'h00}; // addi x1,x0,5
    vecs[1] = '{pc: 32'h4, word: 32'h4020_81B3, op: 7'h33, f3: 3'h0, f7: 7'h20}; // sub  x3,x1,x2
    vecs[2] = '{pc: 32'h8, word: 32'h0020_A423, op: 7'h23, f3: 3'h2, f7: 7'h00}; // sw   x2,8(x1)
    vecs[3] = '{pc: 32'hC, word: 32'h4030_D293, op: 7'h13, f3: 3'h5, f7: 7'h20}; // srai x5,x1,3

    // Reset and first fetch
    req_rdy = 1'b1;
    do_reset();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr",  imem_addr,           32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check("first_instr_valid", 32'(instr_valid), 32'd1);
    check("first_instr",       instr,            vecs[0].word);
    check("first_instr_pc",    instr_pc,         32'h0);

    // Table: in-order delivery with decoded fields
    for (int i = 0; i < 4; i++) begin
      wait_pop("vec_popped");
      check("vec_pc",      pop_pc,       vecs[i].pc);
      check("vec_instr",   pop_instr,    vecs[i].word);
      check("vec_op_code", 32'(pop_op),  32'(vecs[i].op));
      check("vec_func3",   32'(pop_f3),  32'(vecs[i].f3));
      check("vec_func7",   32'(pop_f7),  32'(vecs[i].f7));
    end

    // Backpressure: buffer fills, requests stop, head holds
    repeat (12) cycle(1'b0, 1'b0, 32'h0);
    check("full_instr_valid", 32'(instr_valid),    32'd1);
    check("full_no_req",      32'(imem_req_valid), 32'd0);
    for (int k = 0; k < 30; k++) begin
      req_rdy = 1'($urandom_range(0, 1));
      cycle(1'b1, 1'b0, 32'h0);
    end
    req_rdy = 1'b1;

    // Redirect while waiting on a response
    hold_rsp = 1'b1;
    for (int k = 0; k < 10 && !pend; k++) cycle(1'b1, 1'b0, 32'h0);
    check("wait_reached", 32'(pend), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    hold_rsp = 1'b0;
    wait_pop("redir_wait_pop");
    check("redir_wait_pc", pop_pc, 32'h0000_0100);

    // Redirect together with a response and a decode handshake
    for (int k = 0; k < 20 && !(instr_valid && pend); k++) cycle(1'b0, 1'b0, 32'h0);
    check("coinc_setup", 32'(instr_valid && pend), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("coinc_empty",     32'(instr_valid),    32'd0);
    check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    check("coinc_req_addr",  imem_addr,           32'h0000_0200);
    wait_pop("coinc_pop");
    check("coinc_pop_pc", pop_pc, 32'h0000_0200);

    // Misaligned redirect target
    cycle(1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_fault", 32'(fetch_fault), 32'd1);
    repeat (8) begin
      cycle(1'b1, 1'b0, 32'h0);
      check("trap_no_req",   32'(imem_req_valid), 32'd0);
      check("trap_no_valid", 32'(instr_valid),    32'd0);
    end
    do_reset();
    check("trap_cleared",   32'(fetch_fault),    32'd0);
    check("trap_rst_req",   32'(imem_req_valid), 32'd1);
`else
    last_acc = 1'b0;
    for (int k = 0; k < 10 && !last_acc; k++) cycle(1'b1, 1'b0, 32'h0);
    check("misalign_acc",  32'(last_acc), 32'd1);
    check("misalign_addr", last_acc_addr, 32'h0000_0100);
`endif

    // PC wrap at the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    nacc = 0;
    a1   = 32'h0;
    a2   = 32'h1;
    for (int k = 0; k < 20 && nacc < 2; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (last_acc) begin
        nacc++;
        if (nacc == 1) a1 = last_acc_addr;
        else a2 = last_acc_addr;
      end
    end
    check("wrap_acc_count", 32'(nacc), 32'd2);
    check("wrap_first",     a1,        32'hFFFF_FFFC);
    check("wrap_second",    a2,        32'h0000_0000);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
